// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | inst_fetch_pkg : shared widths, constants and FSM encoding for IF stage   |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package inst_fetch_pkg;

  localparam int STALL_BUS_W = 9;
  localparam int REG_W       = 32;
  localparam int BR_BUS_W    = REG_W + 1;

  localparam logic [REG_W-1:0] ZERO_WORD    = '0;
  localparam logic [REG_W-1:0] PC_RESET_VEC = 32'hbfc00000;
  localparam logic             TRUE_V       = 1'b1;
  localparam logic             FALSE_V      = 1'b0;

  typedef enum logic [1:0] {
    IF_REQ     = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DONE    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_hold_buf.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | inst_fetch_hold_buf : single-entry {pc, inst, adel} fetch holding buffer  |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module inst_fetch_hold_buf
  import inst_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [REG_W-1:0] ld_pc,
  input  logic [REG_W-1:0] ld_inst,
  input  logic             ld_adel,
  output logic             valid,
  output logic [REG_W-1:0] pc,
  output logic [REG_W-1:0] inst,
  output logic             adel
);

  // clear wins over load so a redirect can never leave a stale word behind
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= FALSE_V;
      pc    <= ZERO_WORD;
      inst  <= ZERO_WORD;
      adel  <= FALSE_V;
    end else if (clear) begin
      valid <= FALSE_V;
    end else if (load) begin
      valid <= TRUE_V;
      pc    <= ld_pc;
      inst  <= ld_inst;
      adel  <= ld_adel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | inst_fetch : MIPS IF stage - PC owner, single-outstanding SRAM fetch, IF/ID|
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_PC = PC_RESET_VEC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_BUS_W-1:0] stall,
  input  logic                   flush,
  input  logic [REG_W-1:0]       new_pc,
  input  logic [BR_BUS_W-1:0]    br_bus,
  output logic                   inst_sram_req,
  output logic [REG_W-1:0]       inst_sram_addr,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [REG_W-1:0]       inst_sram_rdata,
  output logic                   stallreq_from_icache,
  output logic                   if_valid,
  output logic [REG_W-1:0]       if_pc,
  output logic [REG_W-1:0]       if_inst,
  output logic                   if_adel
);

  if_state_e        state, state_nxt;
  logic [REG_W-1:0] pc, pc_nxt;
  logic             pend_br_e;
  logic [REG_W-1:0] pend_br_addr;

  logic             br_e;
  logic [REG_W-1:0] br_addr;
  logic             misaligned;
  logic             pc_adv;
  logic             bypass;
  logic             sel_br_e;
  logic [REG_W-1:0] sel_br_addr;

  logic             buf_load, buf_clear, buf_valid, buf_adel, buf_ld_adel;
  logic [REG_W-1:0] buf_pc, buf_inst, buf_ld_inst;

  // PC and IF holds always move together here, so IF's hold bit governs both
  logic unused_stall;
  assign unused_stall = ^{stall[8:3], stall[0]};

  assign {br_e, br_addr} = br_bus;
  assign misaligned      = |pc[1:0];
  assign bypass          = (state == IF_WAIT) && inst_sram_data_ok;

  always_comb begin
    state_nxt   = state;
    buf_load    = FALSE_V;
    buf_ld_inst = ZERO_WORD;
    buf_ld_adel = FALSE_V;
    pc_adv      = FALSE_V;
    unique case (state)
      IF_REQ: begin
        if (misaligned) begin
          buf_load    = TRUE_V;
          buf_ld_adel = TRUE_V;
          state_nxt   = IF_DONE;
        end else if (inst_sram_addr_ok) begin
          state_nxt = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (inst_sram_data_ok) begin
          if (stall[1]) begin
            buf_load    = TRUE_V;
            buf_ld_inst = inst_sram_rdata;
            state_nxt   = IF_DONE;
          end else begin
            pc_adv    = TRUE_V;
            state_nxt = IF_REQ;
          end
        end
      end
      IF_DONE: begin
        if (!stall[1]) begin
          pc_adv    = TRUE_V;
          state_nxt = IF_REQ;
        end
      end
      IF_DISCARD: begin
        if (inst_sram_data_ok) state_nxt = IF_REQ;
      end
      default: state_nxt = IF_REQ;
    endcase

    // A redirect must still swallow any response already owed by the SRAM
    if (flush) begin
      buf_load = FALSE_V;
      pc_adv   = FALSE_V;
      if (((state == IF_WAIT || state == IF_DISCARD) && !inst_sram_data_ok) ||
          (state == IF_REQ && !misaligned && inst_sram_addr_ok))
        state_nxt = IF_DISCARD;
      else
        state_nxt = IF_REQ;
    end
  end

  assign buf_clear = flush || ((state == IF_DONE) && !stall[1]);

  // a branch seen this very cycle is as good as one already pending
  assign sel_br_e    = pend_br_e || br_e;
  assign sel_br_addr = pend_br_e ? pend_br_addr : br_addr;

  always_comb begin
    pc_nxt = pc;
    if (flush)
      pc_nxt = new_pc;
    else if (pc_adv)
      pc_nxt = sel_br_e ? sel_br_addr : pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IF_REQ;
      pc           <= RESET_PC;
      pend_br_e    <= FALSE_V;
      pend_br_addr <= ZERO_WORD;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (flush || pc_adv) begin
        pend_br_e <= FALSE_V;
      end else if (br_e) begin
        pend_br_e    <= TRUE_V;
        pend_br_addr <= br_addr;
      end
    end
  end

  inst_fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .clear   (buf_clear),
    .ld_pc   (pc),
    .ld_inst (buf_ld_inst),
    .ld_adel (buf_ld_adel),
    .valid   (buf_valid),
    .pc      (buf_pc),
    .inst    (buf_inst),
    .adel    (buf_adel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= FALSE_V;
      if_pc    <= ZERO_WORD;
      if_inst  <= ZERO_WORD;
      if_adel  <= FALSE_V;
    end else if (flush || (stall[1] && !stall[2])) begin
      if_valid <= FALSE_V;
      if_pc    <= ZERO_WORD;
      if_inst  <= ZERO_WORD;
      if_adel  <= FALSE_V;
    end else if (!stall[1]) begin
      if (buf_valid) begin
        if_valid <= TRUE_V;
        if_pc    <= buf_pc;
        if_inst  <= buf_inst;
        if_adel  <= buf_adel;
      end else if (bypass) begin
        if_valid <= TRUE_V;
        if_pc    <= pc;
        if_inst  <= inst_sram_rdata;
        if_adel  <= FALSE_V;
      end else begin
        if_valid <= FALSE_V;
        if_pc    <= ZERO_WORD;
        if_inst  <= ZERO_WORD;
        if_adel  <= FALSE_V;
      end
    end
  end

  assign inst_sram_req        = rst && (state == IF_REQ) && !misaligned;
  assign inst_sram_addr       = pc;
  assign stallreq_from_icache = (state == IF_REQ) ||
                                ((state == IF_WAIT) && !inst_sram_data_ok) ||
                                (state == IF_DISCARD);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_inst_fetch : directed self-checking bench for inst_fetch               |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [8:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [32:0] br_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        stallreq_from_icache;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch #(.RESET_PC(32'hbfc00000)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .flush                (flush),
    .new_pc               (new_pc),
    .br_bus               (br_bus),
    .inst_sram_req        (inst_sram_req),
    .inst_sram_addr       (inst_sram_addr),
    .inst_sram_addr_ok    (inst_sram_addr_ok),
    .inst_sram_data_ok    (inst_sram_data_ok),
    .inst_sram_rdata      (inst_sram_rdata),
    .stallreq_from_icache (stallreq_from_icache),
    .if_valid             (if_valid),
    .if_pc                (if_pc),
    .if_inst              (if_inst),
    .if_adel              (if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0; br_bus = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   inst_sram_req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_pc",    if_pc, 0);
    check("rst_inst",  if_inst, 0);
    check("rst_adel",  if_adel, 0);

    // basic hit: addr_ok, data_ok next cycle, word visible two cycles later
    @(negedge clk); rst = 1'b1; inst_sram_addr_ok = 1'b1; #1;
    check("t1_req",  inst_sram_req, 1);
    check("t1_addr", inst_sram_addr, 32'hbfc00000);
    @(negedge clk); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'h24010001; #1;
    check("t1_wait_req",  inst_sram_req, 0);
    check("t1_stallreq",  stallreq_from_icache, 0);
    @(negedge clk); inst_sram_data_ok = 1'b0; #1;
    check("t1_valid", if_valid, 1);
    check("t1_pc",    if_pc, 32'hbfc00000);
    check("t1_inst",  if_inst, 32'h24010001);
    check("t1_req2",  inst_sram_req, 1);
    check("t1_addr2", inst_sram_addr, 32'hbfc00004);

    // branch arriving while the front end is stalled
    stall = 9'h0FF; br_bus = {1'b1, 32'hbfc00100}; inst_sram_addr_ok = 1'b1;
    @(negedge clk); br_bus = '0; inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h3c1d0000; #1;
    @(negedge clk); inst_sram_data_ok = 1'b0; #1;
    check("t2_addr_held", inst_sram_addr, 32'hbfc00004);
    check("t2_no_req",    inst_sram_req, 0);
    check("t2_id_hold",   if_pc, 32'hbfc00000);
    stall = 9'h000;
    @(negedge clk); #1;
    check("t2_br_req",   inst_sram_req, 1);
    check("t2_br_addr",  inst_sram_addr, 32'hbfc00100);
    check("t2_ds_valid", if_valid, 1);
    check("t2_ds_pc",    if_pc, 32'hbfc00004);
    check("t2_ds_inst",  if_inst, 32'h3c1d0000);
    inst_sram_addr_ok = 1'b1;

    // flush while waiting: stale response must be swallowed
    @(negedge clk); inst_sram_addr_ok = 1'b0; flush = 1'b1; new_pc = 32'hbfc00380; #1;
    check("t3_bubble", if_valid, 0);
    @(negedge clk); flush = 1'b0; #1;
    check("t3_disc_req",      inst_sram_req, 0);
    check("t3_disc_stallreq", stallreq_from_icache, 1);
    @(negedge clk); inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef; #1;
    check("t3_stale_req", inst_sram_req, 0);
    @(negedge clk); inst_sram_data_ok = 1'b0; #1;
    check("t3_drop_valid", if_valid, 0);
    check("t3_drop_inst",  if_inst, 0);
    check("t3_new_req",    inst_sram_req, 1);
    check("t3_new_addr",   inst_sram_addr, 32'hbfc00380);

    // misaligned redirect raises adel without touching the SRAM
    flush = 1'b1; new_pc = 32'hbfc00381;
    @(negedge clk); flush = 1'b0; #1;
    check("t4_req_a", inst_sram_req, 0);
    @(negedge clk); #1;
    check("t4_req_b", inst_sram_req, 0);
    @(negedge clk); #1;
    check("t4_valid", if_valid, 1);
    check("t4_adel",  if_adel, 1);
    check("t4_inst",  if_inst, 0);
    check("t4_pc",    if_pc, 32'hbfc00381);
    flush = 1'b1; new_pc = 32'hbfc00400;

    // long miss under an IF-only stall
    @(negedge clk); flush = 1'b0; inst_sram_addr_ok = 1'b1; #1;
    check("t5_req",  inst_sram_req, 1);
    check("t5_addr", inst_sram_addr, 32'hbfc00400);
    @(negedge clk); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'h11112222; #1;
    @(negedge clk); inst_sram_data_ok = 1'b0; #1;
    check("t5_pre_valid", if_valid, 1);
    check("t5_pre_addr",  inst_sram_addr, 32'hbfc00404);
    inst_sram_addr_ok = 1'b1; stall = 9'h003;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); inst_sram_addr_ok = 1'b0; #1;
      check($sformatf("t5_stallreq_%0d", i), stallreq_from_icache, 1);
      check($sformatf("t5_bubble_%0d", i),   if_valid, 0);
    end
    @(negedge clk); stall = 9'h000; inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'h33334444; #1;
    @(negedge clk); inst_sram_data_ok = 1'b0; #1;
    check("t5_valid", if_valid, 1);
    check("t5_pc",    if_pc, 32'hbfc00404);
    check("t5_inst",  if_inst, 32'h33334444);
    check("t5_next",  inst_sram_addr, 32'hbfc00408);
    inst_sram_addr_ok = 1'b1;

    // asynchronous reset in the middle of a wait
    @(negedge clk); inst_sram_addr_ok = 1'b0; #1;
    rst = 1'b0; #1;
    check("t6_req",   inst_sram_req, 0);
    check("t6_valid", if_valid, 0);
    check("t6_pc",    if_pc, 0);
    check("t6_inst",  if_inst, 0);
    check("t6_adel",  if_adel, 0);
    @(negedge clk); rst = 1'b1; #1;
    check("t6_req_after",  inst_sram_req, 1);
    check("t6_addr_after", inst_sram_addr, 32'hbfc00000);

    // flush and branch together: the branch must vanish
    flush = 1'b1; new_pc = 32'hbfc00200; br_bus = {1'b1, 32'hbfc00300};
    @(negedge clk); flush = 1'b0; br_bus = '0; inst_sram_addr_ok = 1'b1; #1;
    check("t7_addr", inst_sram_addr, 32'hbfc00200);
    @(negedge clk); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'h00000001; #1;
    @(negedge clk); inst_sram_data_ok = 1'b0; #1;
    check("t7_next_addr", inst_sram_addr, 32'hbfc00204);
    check("t7_pc",        if_pc, 32'hbfc00200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
